// File: rtl/aclk_controller.sv
// Alarm-clock display sequencer: keypad entry buffer, selects and load strobes.
// Optional ACLK_TIME_CHECK_EN suppresses loads of buffers that are not valid 24h times.
module aclk_controller #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic [3:0] key_ms_hr,
  output logic [3:0] key_ls_hr,
  output logic [3:0] key_ms_min,
  output logic [3:0] key_ls_min,
  output logic       show_alarm,
  output logic       show_new_time,
  output logic       load_alarm,
  output logic       load_new_time,
  output logic       shift
);

  typedef enum logic [2:0] {
    SHOW_TIME,
    KEY_STORED,
    KEY_WAITED,
    KEY_ENTRY,
    SHOW_ALARM,
    SET_ALARM_TIME,
    SET_CURRENT_TIME
  } state_t;

  localparam logic [3:0] LAST = 4'(TIMEOUT_SEC - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       digit;
  logic       timing;
  logic       timeout;
  logic       tmo_exit;
  logic       clr_buf;
  logic       time_ok;

  assign digit   = (key <= 4'd9);
  assign timing  = (state == KEY_WAITED) || (state == KEY_ENTRY);
  assign timeout = (cnt == LAST) && one_second;

`ifdef ACLK_TIME_CHECK_EN
  assign time_ok = (key_ms_hr <= 4'd2)
                && ((key_ms_hr != 4'd2) || (key_ls_hr <= 4'd3))
                && (key_ms_min <= 4'd5);
`else
  assign time_ok = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= SHOW_TIME;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SHOW_TIME: begin
        if (alarm_button) state_nxt = SHOW_ALARM;
        else if (digit)   state_nxt = KEY_STORED;
      end
      KEY_STORED: state_nxt = KEY_WAITED;
      KEY_WAITED: begin
        if (!digit)       state_nxt = KEY_ENTRY;
        else if (timeout) state_nxt = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button)     state_nxt = SET_ALARM_TIME;
        else if (time_button) state_nxt = SET_CURRENT_TIME;
        else if (timeout)     state_nxt = SHOW_TIME;
        else if (digit)       state_nxt = KEY_STORED;
      end
      SHOW_ALARM: begin
        if (!alarm_button) state_nxt = SHOW_TIME;
      end
      SET_ALARM_TIME:   state_nxt = SHOW_TIME;
      SET_CURRENT_TIME: state_nxt = SHOW_TIME;
      default:          state_nxt = SHOW_TIME;
    endcase
  end

  // Inactivity timer restarts in KEY_STORED, so each digit gets a full window
  always_ff @(posedge clock) begin
    if (reset || !timing)              cnt <= '0;
    else if (one_second && cnt != 4'hF) cnt <= cnt + 4'd1;
  end

  assign tmo_exit = timing && (state_nxt == SHOW_TIME);
  assign clr_buf  = tmo_exit
                 || (state == SET_ALARM_TIME)
                 || (state == SET_CURRENT_TIME);

  always_ff @(posedge clock) begin
    if (reset || clr_buf) begin
      key_ms_hr  <= '0;
      key_ls_hr  <= '0;
      key_ms_min <= '0;
      key_ls_min <= '0;
    end else if (state == KEY_STORED) begin
      key_ms_hr  <= key_ls_hr;
      key_ls_hr  <= key_ms_min;
      key_ms_min <= key_ls_min;
      key_ls_min <= key;
    end
  end

  always_comb begin
    show_alarm    = (state == SHOW_ALARM);
    show_new_time = (state == KEY_STORED)
                 || (state == KEY_WAITED)
                 || (state == KEY_ENTRY);
    shift         = (state == KEY_STORED);
    load_alarm    = (state == SET_ALARM_TIME) && time_ok;
    load_new_time = (state == SET_CURRENT_TIME) && time_ok;
  end

endmodule

// File: tb/tb_aclk_controller.sv
// Directed bench for aclk_controller: vector table plus timeout,
// alarm-hold and optional time-check sequences.
module tb_aclk_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic [3:0] key = 4'hF;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
  logic       show_alarm, show_new_time, load_alarm, load_new_time, shift;

  aclk_controller dut (
    .clock(clock),
    .reset(reset),
    .one_second(one_second),
    .key(key),
    .alarm_button(alarm_button),
    .time_button(time_button),
    .key_ms_hr(key_ms_hr),
    .key_ls_hr(key_ls_hr),
    .key_ms_min(key_ms_min),
    .key_ls_min(key_ls_min),
    .show_alarm(show_alarm),
    .show_new_time(show_new_time),
    .load_alarm(load_alarm),
    .load_new_time(load_new_time),
    .shift(shift)
  );

  always #5 clock = ~clock;

  // {show_alarm, show_new_time, load_alarm, load_new_time, shift, buffer}
  logic [20:0] outs;
  assign outs = {show_alarm, show_new_time, load_alarm, load_new_time,
                 shift, key_ms_hr, key_ls_hr, key_ms_min, key_ls_min};

  typedef struct {
    logic        rst;
    logic        sec;
    logic [3:0]  kv;
    logic        ab;
    logic        tb;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [20:0] e(input logic sa, snt, la, lnt, sh,
                                    input logic [15:0] b);
    return {sa, snt, la, lnt, sh, b};
  endfunction

  task automatic add(input logic r, s, input logic [3:0] k,
                     input logic a, t, input logic [20:0] x);
    vec_t v;
    v.rst = r; v.sec = s; v.kv = k; v.ab = a; v.tb = t; v.exp = x;
    vecs.push_back(v);
  endtask

  // Digit held 3 cycles then released with code rel
  task automatic dig(input logic [3:0] k, rel, input logic [15:0] b0, b1);
    add(0, 0, k, 0, 0, e(0, 1, 0, 0, 1, b0));
    add(0, 0, k, 0, 0, e(0, 1, 0, 0, 0, b1));
    add(0, 0, k, 0, 0, e(0, 1, 0, 0, 0, b1));
    add(0, 0, rel, 0, 0, e(0, 1, 0, 0, 0, b1));
  endtask

  task automatic step(input logic r, s, input logic [3:0] k,
                      input logic a, t);
    @(negedge clock);
    reset = r; one_second = s; key = k;
    alarm_button = a; time_button = t;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [20:0] got, exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic type_key(input logic [3:0] k);
    repeat (3) step(0, 0, k, 0, 0);
    step(0, 0, 4'hF, 0, 0);
  endtask

  int n_a;
  int shifts;
  int strobes;

  initial begin
    // Scenario A: reset, ignored code 12, keys 1-4, time_button
    add(1, 0, 4'hF, 0, 0, e(0, 0, 0, 0, 0, 16'h0000));
    add(0, 0, 4'hC, 0, 0, e(0, 0, 0, 0, 0, 16'h0000));
    dig(4'd1, 4'hF, 16'h0000, 16'h0001);
    dig(4'd2, 4'hA, 16'h0001, 16'h0012);
    dig(4'd3, 4'hF, 16'h0012, 16'h0123);
    dig(4'd4, 4'hE, 16'h0123, 16'h1234);
    add(0, 0, 4'hF, 0, 1, e(0, 0, 0, 1, 0, 16'h1234));
    add(0, 0, 4'hF, 0, 0, e(0, 0, 0, 0, 0, 16'h0000));
    add(0, 0, 4'hF, 0, 0, e(0, 0, 0, 0, 0, 16'h0000));
    n_a = vecs.size();
    // Scenario B: keys 0,7,3,0 then both buttons, alarm wins
    dig(4'd0, 4'hF, 16'h0000, 16'h0000);
    dig(4'd7, 4'hF, 16'h0000, 16'h0007);
    dig(4'd3, 4'hF, 16'h0007, 16'h0073);
    dig(4'd0, 4'hF, 16'h0073, 16'h0730);
    add(0, 0, 4'hF, 1, 1, e(0, 0, 1, 0, 0, 16'h0730));
    add(0, 0, 4'hF, 0, 1, e(0, 0, 0, 0, 0, 16'h0000));
    add(0, 0, 4'hF, 0, 0, e(0, 0, 0, 0, 0, 16'h0000));
    // Scenario C: reset mid-entry
    dig(4'd1, 4'hF, 16'h0000, 16'h0001);
    dig(4'd2, 4'hF, 16'h0001, 16'h0012);
    add(1, 0, 4'hF, 0, 0, e(0, 0, 0, 0, 0, 16'h0000));
    add(0, 0, 4'hF, 0, 0, e(0, 0, 0, 0, 0, 16'h0000));
    // Scenario D: reset during a load strobe
    dig(4'd9, 4'hF, 16'h0000, 16'h0009);
    add(0, 0, 4'hF, 0, 1, e(0, 0, 0, 1, 0, 16'h0009));
    add(1, 0, 4'hF, 0, 1, e(0, 0, 0, 0, 0, 16'h0000));
    add(0, 0, 4'hF, 0, 0, e(0, 0, 0, 0, 0, 16'h0000));

    shifts = 0;
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].sec, vecs[i].kv, vecs[i].ab, vecs[i].tb);
      check($sformatf("vec%0d", i), outs, vecs[i].exp);
      if (i < n_a && shift) shifts++;
    end
    check("shift_count", 21'(shifts), 21'd4);

    // Timeout: key 5, then 9 pulses stay in entry, 10th abandons
    step(1, 0, 4'hF, 0, 0);
    type_key(4'd5);
    strobes = 0;
    for (int p = 0; p < 9; p++) begin
      step(0, 1, 4'hF, 0, 0);
      if (load_alarm || load_new_time) strobes++;
      step(0, 0, 4'hF, 0, 0);
      if (load_alarm || load_new_time) strobes++;
    end
    check("tmo_9_pulses", outs, e(0, 1, 0, 0, 0, 16'h0005));
    step(0, 1, 4'hF, 0, 0);
    if (load_alarm || load_new_time) strobes++;
    check("tmo_10th_pulse", outs, e(0, 0, 0, 0, 0, 16'h0000));
    step(0, 0, 4'hF, 0, 0);
    check("tmo_after", outs, e(0, 0, 0, 0, 0, 16'h0000));
    check("tmo_no_strobe", 21'(strobes), 21'd0);

    // Alarm button held 20 cycles in SHOW_TIME
    for (int c = 0; c < 20; c++) begin
      step(0, 0, 4'hF, 1, 0);
      check($sformatf("alarm_hold%0d", c), outs, e(1, 0, 0, 0, 0, 16'h0));
    end
    step(0, 0, 4'hF, 0, 0);
    check("alarm_release", outs, e(0, 0, 0, 0, 0, 16'h0000));

`ifdef ACLK_TIME_CHECK_EN
    type_key(4'd2); type_key(4'd5); type_key(4'd0); type_key(4'd0);
    step(0, 0, 4'hF, 0, 1);
    check("chk_invalid", outs, e(0, 0, 0, 0, 0, 16'h2500));
    step(0, 0, 4'hF, 0, 0);
    check("chk_invalid_clr", outs, e(0, 0, 0, 0, 0, 16'h0000));
    type_key(4'd2); type_key(4'd3); type_key(4'd5); type_key(4'd9);
    step(0, 0, 4'hF, 0, 1);
    check("chk_valid", outs, e(0, 0, 0, 1, 0, 16'h2359));
    step(0, 0, 4'hF, 0, 0);
    check("chk_valid_clr", outs, e(0, 0, 0, 0, 0, 16'h0000));
`else
    type_key(4'd2); type_key(4'd5); type_key(4'd0); type_key(4'd0);
    step(0, 0, 4'hF, 0, 1);
    check("nochk_load", outs, e(0, 0, 0, 1, 0, 16'h2500));
    step(0, 0, 4'hF, 0, 0);
    check("nochk_clr", outs, e(0, 0, 0, 0, 0, 16'h0000));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aclk_controller.md
# aclk_controller

Sequencing controller for the alarm-clock display path. Decodes keypad and button activity into a Moore state machine, holds the 4-digit key-entry buffer, and generates the per-digit key values plus the `show_alarm`/`show_new_time` selects. These outputs feed the four per-digit LCD driver instances. It also issues one-cycle load strobes to the alarm and time registers, and abandons key entry after a 10-second inactivity timeout.

## Interface
Parameters:
- `TIMEOUT_SEC`, default 10: number of `one_second` pulses without a new key before entry is abandoned (range 2..15).

Ports:
- `clock`  in  1  system clock, all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `one_second`  in  1  one-cycle tick, once per second.
- `key`  in  4  keypad code.
  - 0–9 is a digit.
  - 4'hF is NOKEY.
  - 10–14 are treated as NOKEY.
- `alarm_button`  in  1  level, high while pressed.
- `time_button`  in  1  level, high while pressed.
- `key_ms_hr`, `key_ls_hr`, `key_ms_min`, `key_ls_min`  out  4 each  key-entry buffer digits.
- `show_alarm`  out  1  display selects alarm time.
- `show_new_time`  out  1  display selects key buffer.
- `load_alarm`  out  1  one-cycle strobe: copy key buffer into alarm register.
- `load_new_time`  out  1  one-cycle strobe: copy key buffer into current-time counter.
- `shift`  out  1  observability strobe: key buffer shifting this cycle.

## Operation
- States: SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM, SET_ALARM_TIME, SET_CURRENT_TIME. Outputs are decoded from the state register only (Moore).
- SHOW_TIME:
  - `alarm_button` → SHOW_ALARM.
  - Else a digit → KEY_STORED.
  - Else stay.
- KEY_STORED: `shift`=1 → KEY_WAITED, unconditionally.
- KEY_WAITED (debounce, waiting for key release):
  - `key`==NOKEY → KEY_ENTRY.
  - Else timeout → SHOW_TIME.
- KEY_ENTRY, priority high to low:
  1. `alarm_button` → SET_ALARM_TIME.
  2. `time_button` → SET_CURRENT_TIME.
  3. Timeout → SHOW_TIME.
  4. Digit → KEY_STORED.
- SHOW_ALARM: `show_alarm`=1. Stay while `alarm_button` is high; release → SHOW_TIME.
- SET_ALARM_TIME: `load_alarm`=1 for one cycle → SHOW_TIME.
- SET_CURRENT_TIME: `load_new_time`=1 for one cycle → SHOW_TIME.
- `show_new_time`=1 in KEY_STORED, KEY_WAITED and KEY_ENTRY; 0 elsewhere.
- Key buffer on `shift` (left shift, newest digit enters at `ls_min`):
  - ms_hr ← ls_hr
  - ls_hr ← ms_min
  - ms_min ← ls_min
  - ls_min ← `key` sampled in the KEY_STORED cycle
- Buffer clear to 0:
  - the cycle after any load strobe;
  - on a timeout exit to SHOW_TIME;
  - on reset.
- Timeout counter (4 bits):
  - Cleared in every state other than KEY_WAITED and KEY_ENTRY.
  - Increments on `one_second` in those two states.
  - Timeout is true when the counter equals `TIMEOUT_SEC`-1 and `one_second`=1. The timer therefore restarts at every stored digit.
  - The counter saturates and never wraps.
- Fewer than 4 digits before a load: the buffer holds leading zeros (e.g. keys 4,5 → 0,0,4,5).
- More than 4 digits: the oldest digit is shifted out.

## Timing
- Reset (synchronous, applied at a `clock` edge):
  - state SHOW_TIME;
  - buffer 0000;
  - counter 0;
  - all strobes and selects 0.
- Reset has priority over every transition, including mid-entry and during a load strobe.
- Digit seen in SHOW_TIME at edge n:
  - `shift`=1 in cycle n+1;
  - buffer updated at edge n+2;
  - `show_new_time` high from n+1.
- Button seen in KEY_ENTRY at edge n: strobe high in cycle n+1 only. SHOW_TIME and the buffer clear follow at n+2.
- `alarm_button` and `time_button` both high in KEY_ENTRY: the alarm wins. `time_button` is ignored until the next entry.
- A digit held across multiple cycles is stored exactly once.
- `shift`, `load_alarm` and `load_new_time` are never high for two consecutive cycles.

## Configuration
- `ACLK_TIME_CHECK_EN` defined:
  - Entering SET_ALARM_TIME or SET_CURRENT_TIME checks the buffer is a valid 24h time: ms_hr≤2; if ms_hr==2 then ls_hr≤3; ms_min≤5.
  - An invalid buffer suppresses the load strobe. The state still returns to SHOW_TIME and the buffer still clears.
- Macro undefined: strobes fire unconditionally and no check logic is synthesised.

## Test plan
- Reset mid-entry (after keys 1,2): next cycle has state SHOW_TIME, buffer 0000 and all outputs 0.
- Keys 1,2,3,4 (each held 3 cycles, NOKEY between), then `time_button`:
  - buffer 1,2,3,4;
  - `load_new_time` high exactly 1 cycle;
  - buffer 0000 afterwards;
  - `shift` pulsed exactly 4 times.
- Keys 0,7,3,0, then `alarm_button` and `time_button` together: `load_alarm` pulses once, `load_new_time` stays 0.
- Key 5, then 10 `one_second` pulses with no key: returns to SHOW_TIME after the 10th pulse, buffer 0000, no strobe. With only 9 pulses it remains in KEY_ENTRY.
- `alarm_button` held 20 cycles in SHOW_TIME: `show_alarm`=1 for those cycles, 0 one cycle after release, `show_new_time`=0 throughout.
- With `ACLK_TIME_CHECK_EN`:
  - keys 2,5,0,0 then `time_button` → no `load_new_time`, buffer cleared;
  - keys 2,3,5,9 → `load_new_time` pulses.
